// File: rtl/posit_decode_pipe_pkg.sv
// Shared types and helpers for the posit field decoder.
package posit_decode_pipe_pkg;

    typedef enum logic {POS = 1'b0, NEG = 1'b1} sign_t;

    typedef struct packed {
        logic zero;
        logic nar;
    } posit_special_t;

    function automatic int regime_width(input int width);
        return $clog2(width) + 1;
    endfunction

    // Length of the leading run of ones in the top n bits of a left-aligned vector.
    function automatic int count_lead_one(input logic [31:0] v, input int n);
        int   cnt;
        logic run;
        cnt = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                if (run && v[31-i]) cnt = cnt + 1;
                else run = 1'b0;
            end
        end
        return cnt;
    endfunction

    function automatic int count_lead_zero(input logic [31:0] v, input int n);
        return count_lead_one(~v, n);
    endfunction

endpackage

// File: rtl/posit_decode_pipe_regime_scan.sv
// Combinational regime scan: run length, polarity and the bits left after the terminator.
module posit_regime_scan
    import posit_decode_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int W_REG = regime_width(WIDTH)
) (
    input  logic [WIDTH-2:0] mag,
    output logic [W_REG-1:0] run,
    output logic             polarity,
    output logic [WIDTH-2:0] residual
);

    logic [31:0] mag_aligned;
    int          run_len;

    always_comb begin
        mag_aligned = {mag, {(33-WIDTH){1'b0}}};
        polarity    = mag[WIDTH-2];
        run_len     = polarity ? count_lead_one(mag_aligned, WIDTH-1)
                               : count_lead_zero(mag_aligned, WIDTH-1);
        run         = W_REG'(run_len);
        // Drop the run and its terminator; a run filling the word shifts everything out.
        residual    = mag << (run_len + 1);
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// Three-stage streaming posit decoder with valid/ready backpressure.
// Optional out_scale port enabled by defining POSIT_DECODE_SCALE_EN.
module posit_decode_pipe
    import posit_decode_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ES    = 1,
    parameter int W_REG = regime_width(WIDTH),
    parameter int W_EXP = (ES > 0) ? ES : 1,
    parameter int W_MAN = WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_posit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output sign_t                   out_sign,
    output logic signed [W_REG-1:0] out_regime,
    output logic [W_EXP-1:0]        out_exponent,
    output logic [W_MAN-1:0]        out_mantissa,
    output logic                    out_zero,
    output logic                    out_nar
`ifdef POSIT_DECODE_SCALE_EN
   ,output logic signed [W_REG+ES-1:0] out_scale
`endif
);

    logic vld_p0, vld_p1, vld_p2;
    logic ld_p0, ld_p1, ld_p2;

    // A stage may load when empty or when its contents move on this cycle.
    assign ld_p2     = !vld_p2 || out_ready;
    assign ld_p1     = !vld_p1 || ld_p2;
    assign ld_p0     = !vld_p0 || ld_p1;
    assign in_ready  = ld_p0;
    assign out_valid = vld_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (ld_p0) vld_p0 <= in_valid;
            if (ld_p1) vld_p1 <= vld_p0;
            if (ld_p2) vld_p2 <= vld_p1;
        end
    end

    // ---- S1: sign, special flags, magnitude ----
    sign_t            sign_p0;
    posit_special_t   spec_p0;
    logic [WIDTH-2:0] mag_p0;
    logic [WIDTH-2:0] mag_c;

    assign mag_c = in_posit[WIDTH-1] ? (~in_posit[WIDTH-2:0] + 1'b1) : in_posit[WIDTH-2:0];

    always_ff @(posedge clk) begin
        if (ld_p0 && in_valid) begin
            sign_p0      <= sign_t'(in_posit[WIDTH-1]);
            spec_p0.zero <= (in_posit == '0);
            spec_p0.nar  <= (in_posit == {1'b1, {(WIDTH-1){1'b0}}});
            mag_p0       <= mag_c;
        end
    end

    // ---- S2: regime run, polarity, residual bits ----
    logic [W_REG-1:0] run_c, run_p1;
    logic             pol_c, pol_p1;
    logic [WIDTH-2:0] res_c, res_p1;
    sign_t            sign_p1;
    posit_special_t   spec_p1;

    posit_regime_scan #(.WIDTH(WIDTH), .W_REG(W_REG)) u_scan (
        .mag      (mag_p0),
        .run      (run_c),
        .polarity (pol_c),
        .residual (res_c)
    );

    always_ff @(posedge clk) begin
        if (ld_p1 && vld_p0) begin
            run_p1  <= run_c;
            pol_p1  <= pol_c;
            res_p1  <= res_c;
            sign_p1 <= sign_p0;
            spec_p1 <= spec_p0;
        end
    end

    // ---- S3: final fields ----
    logic signed [W_REG-1:0] regime_c;
    logic [W_EXP-1:0]        exp_c;
    logic [WIDTH-2:0]        frac_c;
    logic                    special_c;

    assign regime_c  = pol_p1 ? signed'(run_p1 - W_REG'(1)) : signed'(-run_p1);
    assign frac_c    = res_p1 << ES;
    assign special_c = spec_p1.zero || spec_p1.nar;

    if (ES > 0) begin : g_exp
        assign exp_c = res_p1[WIDTH-2 -: W_EXP];
    end else begin : g_noexp
        assign exp_c = '0;
    end

`ifdef POSIT_DECODE_SCALE_EN
    localparam int W_SC = W_REG + ES;
    logic signed [W_SC-1:0] scale_c;
    assign scale_c = (W_SC'(regime_c) <<< ES) + W_SC'(signed'({1'b0, exp_c}));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sign     <= POS;
            out_regime   <= '0;
            out_exponent <= '0;
            out_mantissa <= '0;
            out_zero     <= 1'b0;
            out_nar      <= 1'b0;
`ifdef POSIT_DECODE_SCALE_EN
            out_scale    <= '0;
`endif
        end else if (ld_p2 && vld_p1) begin
            out_sign     <= special_c ? POS : sign_p1;
            out_regime   <= special_c ? '0 : regime_c;
            out_exponent <= special_c ? '0 : exp_c;
            out_mantissa <= special_c ? '0 : {1'b1, frac_c};
            out_zero     <= spec_p1.zero;
            out_nar      <= spec_p1.nar;
`ifdef POSIT_DECODE_SCALE_EN
            out_scale    <= special_c ? '0 : scale_c;
`endif
        end
    end

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Self-checking bench for posit_decode_pipe: directed cases, backpressure, reset, random stream.
module tb_posit_decode_pipe;
    import posit_decode_pipe_pkg::*;

    localparam int WIDTH = 8;
    localparam int ES    = 1;
    localparam int W_REG = 4;
    localparam int W_EXP = 1;
    localparam int W_MAN = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_posit = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    sign_t                   out_sign;
    logic signed [W_REG-1:0] out_regime;
    logic [W_EXP-1:0]        out_exponent;
    logic [W_MAN-1:0]        out_mantissa;
    logic                    out_zero;
    logic                    out_nar;
`ifdef POSIT_DECODE_SCALE_EN
    logic signed [W_REG+ES-1:0] out_scale;
`endif

    posit_decode_pipe #(.WIDTH(WIDTH), .ES(ES)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_posit     (in_posit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_regime   (out_regime),
        .out_exponent (out_exponent),
        .out_mantissa (out_mantissa),
        .out_zero     (out_zero),
`ifdef POSIT_DECODE_SCALE_EN
        .out_scale    (out_scale),
`endif
        .out_nar      (out_nar)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int sign;
        int regime;
        int exponent;
        int mantissa;
        int zero;
        int nar;
        int scale;
    } dec_t;

    // Reference decode: walk the body bits MSB first as a plain bit list.
    function automatic dec_t model(input int p);
        dec_t d;
        int   b[WIDTH-1];
        int   v, idx, k, first;
        d = '{default: 0};
        if (p == 0) d.zero = 1;
        else if (p == (1 << (WIDTH-1))) d.nar = 1;
        else begin
            d.sign = (p >> (WIDTH-1)) & 1;
            v = d.sign ? (1 << WIDTH) - p : p;
            for (int i = 0; i < WIDTH-1; i++) b[i] = (v >> (WIDTH-2-i)) & 1;
            first = b[0];
            k = 0;
            idx = 0;
            while (idx < WIDTH-1 && b[idx] == first) begin
                k++;
                idx++;
            end
            d.regime = first ? k - 1 : -k;
            idx++;
            for (int j = 0; j < ES; j++) begin
                d.exponent = d.exponent * 2 + ((idx < WIDTH-1) ? b[idx] : 0);
                idx++;
            end
            d.mantissa = 1;
            for (int j = 0; j < WIDTH-1; j++) begin
                d.mantissa = d.mantissa * 2 + ((idx < WIDTH-1) ? b[idx] : 0);
                idx++;
            end
            d.scale = d.regime * (1 << ES) + d.exponent;
        end
        return d;
    endfunction

    function automatic logic [15:0] out_word();
        return {out_sign, out_regime, out_exponent, out_mantissa, out_zero, out_nar};
    endfunction

    dec_t        exp_q[$];
    int          accepted = 0;
    int          delivered = 0;
    logic        hold_pending = 1'b0;
    logic [15:0] snap;
    logic        saw_not_ready = 1'b0;

    // Scoreboard and hold monitor, sampled mid-cycle.
    always @(negedge clk) begin
        dec_t d;
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) check("hold_stable", out_word(), snap);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out_valid", 1, 0);
                else begin
                    d = exp_q.pop_front();
                    check("sign", out_sign, d.sign);
                    check("regime", int'(out_regime), d.regime);
                    check("exponent", out_exponent, d.exponent);
                    check("mantissa", out_mantissa, d.mantissa);
                    check("zero", out_zero, d.zero);
                    check("nar", out_nar, d.nar);
`ifdef POSIT_DECODE_SCALE_EN
                    check("scale", int'(out_scale), d.scale);
`endif
                    delivered++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_posit));
                accepted++;
            end
            if (!in_ready) saw_not_ready = 1'b1;
            hold_pending = out_valid && !out_ready;
            snap = out_word();
        end
    end

    task automatic drive(input logic [7:0] w);
        int n;
        in_valid = 1'b1;
        in_posit = w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("drive_timeout_in_ready", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("delivered_vs_accepted", delivered, accepted);
    endtask

    task automatic directed(input logic [7:0] w, input int sgn, input int rg, input int ex,
                            input int mn, input int z, input int na);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_posit = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("latency_not_early", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_3", out_valid, 1);
        check("dir_sign", out_sign, sgn);
        check("dir_regime", int'(out_regime), rg);
        check("dir_exponent", out_exponent, ex);
        check("dir_mantissa", out_mantissa, mn);
        check("dir_zero", out_zero, z);
        check("dir_nar", out_nar, na);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] specials[6] = '{8'h00, 8'h80, 8'h7F, 8'h01, 8'hFF, 8'h81};
    logic       stim_done = 1'b0;
    int         stale_seen;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_outputs", out_word(), 0);
        @(negedge clk);
        rst = 1'b0;

        directed(8'h40, 0, 0, 0, 8'h80, 0, 0);
        directed(8'h38, 0, -1, 1, 8'hC0, 0, 0);
        directed(8'h60, 0, 1, 0, 8'h80, 0, 0);
        directed(8'hC0, 1, 0, 0, 8'h80, 0, 0);
        directed(8'h7F, 0, 6, 0, 8'h80, 0, 0);
        directed(8'h01, 0, -6, 0, 8'h80, 0, 0);
        directed(8'h00, 0, 0, 0, 8'h00, 1, 0);
        directed(8'h80, 0, 0, 0, 8'h00, 0, 1);

        // Backpressure: stall the output for 4 cycles while streaming.
        saw_not_ready = 1'b0;
        fork
            begin
                drive(8'h40);
                drive(8'h60);
                drive(8'h38);
                drive(8'hC0);
                drive(8'h7F);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready_dropped_when_full", saw_not_ready, 1);

        // Asynchronous reset with three words in flight.
        drive(8'h40);
        drive(8'h38);
        drive(8'h7F);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_outputs", out_word(), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_release", in_ready, 1);
        stale_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale_seen++;
        end
        check("no_stale_after_reset", stale_seen, 0);
        accepted = 0;
        delivered = 0;

        // Random stream with random output stalls.
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    if ($urandom_range(0, 7) == 0) drive(specials[$urandom_range(0, 5)]);
                    else drive(8'($urandom));
                end
                in_valid = 1'b0;
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
